// File: rtl/reg32_write_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them to consecutive register-file lines.
// The write strobe rises one cycle after the final byte is accepted. Optional parity checking is enabled by LOADER_PARITY_EN.
module reg32_write_loader #(
    parameter int LINES = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          base_load,
    input  logic [AW-1:0] base_addr,
    input  logic          byte_valid,
    output logic          byte_ready,
    input  logic [7:0]    byte_in,
    input  logic          flush,
`ifdef LOADER_PARITY_EN
    input  logic          byte_par,
    output logic          par_err,
`endif
    output logic          write_en,
    output logic [AW-1:0] write_line,
    output logic [31:0]   data_out,
    output logic          busy,
    output logic          wrap_pulse
);

    typedef enum logic {COLLECT, WRITE} state_t;

    localparam logic [AW-1:0] LAST_LINE = AW'(LINES - 1);

    state_t        state, state_n;
    logic [1:0]    byte_cnt, byte_cnt_n;
    logic [31:0]   word_q, word_n, word_fill;
    logic [AW-1:0] ptr, ptr_n;
    logic          bad_q, bad_n, bad_word;
    logic          drop_q, drop_n;
    logic          write_en_n, wrap_n;
    logic [AW-1:0] line_n;
    logic [31:0]   data_n;
    logic          hs, byte_bad, finish_word;

    assign byte_ready = (state == COLLECT) && !reset && !base_load;
    assign hs         = byte_valid && byte_ready;
    assign busy       = (byte_cnt != 2'd0) || (state == WRITE);

`ifdef LOADER_PARITY_EN
    assign byte_bad = (byte_par != ^byte_in);
    assign par_err  = drop_q;
`else
    assign byte_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= COLLECT;
            byte_cnt   <= 2'd0;
            word_q     <= 32'd0;
            ptr        <= '0;
            bad_q      <= 1'b0;
            drop_q     <= 1'b0;
            write_en   <= 1'b0;
            write_line <= '0;
            data_out   <= 32'd0;
            wrap_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            byte_cnt   <= byte_cnt_n;
            word_q     <= word_n;
            ptr        <= ptr_n;
            bad_q      <= bad_n;
            drop_q     <= drop_n;
            write_en   <= write_en_n;
            write_line <= line_n;
            data_out   <= data_n;
            wrap_pulse <= wrap_n;
        end
    end

    always_comb begin
        state_n    = state;
        byte_cnt_n = byte_cnt;
        word_n     = word_q;
        ptr_n      = ptr;
        bad_n      = bad_q;
        drop_n     = 1'b0;
        write_en_n = 1'b0;
        line_n     = write_line;
        data_n     = data_out;
        wrap_n     = 1'b0;

        // Unfilled lanes stay zero because word_q is cleared at every word boundary.
        word_fill = word_q;
        if (hs) begin
            word_fill[{byte_cnt, 3'b000} +: 8] = byte_in;
        end
        bad_word    = bad_q || (hs && byte_bad);
        finish_word = (hs && (byte_cnt == 2'd3)) || (flush && (hs || (byte_cnt != 2'd0)));

        case (state)
            COLLECT: begin
                if (base_load) begin
                    ptr_n      = base_addr;
                    byte_cnt_n = 2'd0;
                    word_n     = 32'd0;
                    bad_n      = 1'b0;
                end else if (finish_word) begin
                    state_n    = WRITE;
                    byte_cnt_n = 2'd0;
                    word_n     = 32'd0;
                    bad_n      = 1'b0;
                    if (bad_word) begin
                        drop_n = 1'b1;
                    end else begin
                        write_en_n = 1'b1;
                        line_n     = ptr;
                        data_n     = word_fill;
                        wrap_n     = (ptr == LAST_LINE);
                    end
                end else if (hs) begin
                    byte_cnt_n = byte_cnt + 2'd1;
                    word_n     = word_fill;
                    bad_n      = bad_word;
                end
            end
            WRITE: begin
                // A dropped word keeps its line so the next good word lands there.
                state_n = COLLECT;
                if (!drop_q) begin
                    ptr_n = ptr + AW'(1);
                end
            end
            default: state_n = COLLECT;
        endcase
    end

endmodule

// File: doc/reg32_write_loader.md
Name: reg32_write_loader

Overview:
- Upstream feeder for the 16x32 register file (reg32_ad_new).
- Accepts an 8-bit byte stream on a valid/ready handshake and packs four bytes into one 32-bit word, little-endian.
- Issues one write per word on the register file write port: write_en, write_line, data.
- Keeps an auto-incrementing line pointer so successive words fill consecutive lines, wrapping 15->0.

Parameters:
- LINES, 16, number of register-file lines; pointer wraps modulo LINES.
- AW, 4, line address width; must satisfy 2**AW == LINES.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous reset, active-high.
- base_load  input  1  load base_addr into the line pointer.
- base_addr  input  AW  new pointer value.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader can accept a byte this cycle.
- byte_in  input  8  data byte.
- flush  input  1  write a partial word with its upper lanes zero-filled.
- write_en  output  1  register file write strobe.
- write_line  output  AW  register file write address.
- data_out  output  32  word to the register file data_in.
- busy  output  1  a partial word is held, or a write is in progress.
- wrap_pulse  output  1  one-cycle pulse when line LINES-1 is written.

Behaviour:
- Interface is fixed: one clock (clk); reset is synchronous and active-high.
- Reset (sampled high at a rising edge):
  - state=COLLECT, byte_cnt=0, ptr=0.
  - Outputs: write_en=0, write_line=0, data_out=0, busy=0, wrap_pulse=0.
  - byte_ready=0 while reset is high.
  - Reset mid-word discards the partial bytes; no write is issued.
- Handshake: a byte transfers on a rising edge where byte_valid=1 and byte_ready=1. byte_valid may stay high; no byte is lost or duplicated.
- byte_ready = (state==COLLECT) and not reset and not base_load.
- COLLECT state:
  - Each accepted byte goes to lane byte_cnt (byte 0 -> bits 7:0, ... byte 3 -> bits 31:24); byte_cnt increments.
  - Accepting the 4th byte -> WRITE at the next edge, byte_cnt cleared.
  - flush=1 with byte_cnt>0, or flush together with a handshake -> WRITE. The accepted byte is included and unfilled lanes are 0. If that byte was the 4th, this is an ordinary full write.
  - flush with byte_cnt=0 and no handshake: ignored.
  - base_load=1: ptr<=base_addr, byte_cnt<=0, partial word discarded, no write.
- WRITE state, exactly one cycle:
  - All outputs are registered: write_en=1, write_line=ptr, data_out=assembled word, byte_ready=0.
  - Next edge: ptr<=(ptr+1) mod LINES, state<=COLLECT, write_en<=0.
  - data_out and write_line hold their last values while idle.
- Latency and throughput:
  - write_en rises in the cycle after the edge that accepted the final byte.
  - The register file captures at the edge ending that cycle.
  - Peak rate is 4 bytes per 5 cycles.
- wrap_pulse=1 concurrently with write_en when write_line==LINES-1; 0 otherwise.
- busy=1 when byte_cnt>0 or state==WRITE.
- base_load during WRITE is ignored: the write uses the old ptr, then ptr increments.

Optional Feature:
- Macro: LOADER_PARITY_EN.
- Defined:
  - Adds input byte_par (1 bit, even parity over byte_in, sampled with the handshake) and output par_err (1 bit).
  - Any accepted byte with mismatched parity marks the word bad.
  - A bad word is dropped instead of written: no write_en, ptr unchanged, state returns to COLLECT.
  - par_err pulses 1 for one cycle in that slot.
- Undefined: neither port exists; all words are written.

Test Plan:
- Reset, then stream bytes F0,FF,00,00 with byte_valid held high -> write_en one cycle, write_line=0, data_out=0000FFF0. Next word goes to line 1.
- base_load with base_addr=2, then bytes 11,22,33,44 -> write_line=2, data_out=44332211, busy falls after the write.
- Bytes AA,BB then flush -> write_line=ptr, data_out=0000BBAA. Flush with byte_cnt=0 -> no write_en.
- base_addr=14, three full words -> lines 14,15,0; wrap_pulse high only with the line-15 write.
- Reset asserted after 2 bytes -> no write, ptr=0. The next 4 bytes write to line 0 with only the new bytes.
- LOADER_PARITY_EN: one byte with a bad byte_par -> par_err pulse, no write_en, ptr unchanged. The following good word lands at the same line.
